// File: rtl/normalize_unit.sv
// rtl/normalize_unit.sv - 32-bit leading/trailing zero normalizer, 5-step binary shift search
module normalize_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_shift,
    output logic        out_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [5:0]  count_q, count_d;
    logic        zero_q, zero_d;
    logic [2:0]  step_q, step_d;
    logic        mode_q, mode_d;

    logic [5:0]  step_amt;
    logic [31:0] hi_mask;
    logic [31:0] lo_mask;
    logic        step_hit;
    logic        last_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= 32'd0;
            count_q <= 6'd0;
            zero_q  <= 1'b0;
            step_q  <= 3'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (step_q == 3'd4) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        step_amt = 6'd0;
        case (step_q)
            3'd0:    step_amt = 6'd16;
            3'd1:    step_amt = 6'd8;
            3'd2:    step_amt = 6'd4;
            3'd3:    step_amt = 6'd2;
            3'd4:    step_amt = 6'd1;
            default: step_amt = 6'd0;
        endcase
    end

    // Steps only reach 31 in total; an all-zero operand earns one extra count on the last step.
    always_comb begin
        hi_mask   = ~(32'hFFFF_FFFF >> step_amt);
        lo_mask   = ~(32'hFFFF_FFFF << step_amt);
        step_hit  = mode_q ? ((work_q & lo_mask) == 32'd0) : ((work_q & hi_mask) == 32'd0);
        last_zero = (step_q == 3'd4) && zero_q;
    end

    always_comb begin
        work_d  = work_q;
        count_d = count_q;
        zero_d  = zero_q;
        step_d  = step_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    mode_d  = in_mode;
                    count_d = 6'd0;
                    zero_d  = (in_data == 32'd0);
                    step_d  = 3'd0;
                end
            end
            RUN: begin
                step_d = step_q + 3'd1;
                if (step_hit) begin
                    work_d  = mode_q ? (work_q >> step_amt) : (work_q << step_amt);
                    count_d = count_q + step_amt + {5'd0, last_zero};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = work_q;
        out_shift = count_q;
        out_zero  = zero_q;
    end

endmodule

// File: tb/tb_normalize_unit.sv
// tb/tb_normalize_unit.sv - scoreboard bench for normalize_unit with directed and random operands
module tb_normalize_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_shift;
    logic        out_zero;

    int compared;
    int mismatched;
    logic [38:0] sb[$];

    normalize_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {zero, shift, data} found by scanning bit by bit.
    function automatic logic [38:0] model(input logic [31:0] d, input logic m);
        int n;
        logic [31:0] r;
        if (d == 32'd0) return {1'b1, 6'd32, 32'd0};
        n = 0;
        if (!m) begin
            while (!d[31-n]) n++;
            r = d << n;
        end else begin
            while (!d[n]) n++;
            r = d >> n;
        end
        return {1'b0, 6'(n), r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] d, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        sb.push_back(model(d, m));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("accept_in_ready_low", 32'(in_ready), 32'd0);
    endtask

    task automatic finish_op(input int hold);
        int n;
        logic [38:0] exp;
        n = 0;
        while (!out_valid && n < 20) begin
            in_data  = $urandom;
            in_mode  = 1'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'd5);
        exp = sb.pop_front();
        check("out_data", out_data, exp[31:0]);
        check("out_shift", 32'(out_shift), 32'(exp[37:32]));
        check("out_zero", 32'(out_zero), 32'(exp[38]));
        for (int i = 0; i < hold; i++) begin
            in_data  = $urandom;
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_data", out_data, exp[31:0]);
            check("hold_shift", 32'(out_shift), 32'(exp[37:32]));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [31:0] d, input logic m, input int hold);
        start_op(d, m);
        finish_op(hold);
    endtask

    initial begin
        logic [31:0] r;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        in_mode    = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_shift", 32'(out_shift), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);

        // First accept on the very first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0000_0001, 1'b0, 0);
        run_op(32'h8000_0000, 1'b1, 0);
        run_op(32'h8000_0000, 1'b0, 1);
        run_op(32'h0000_0000, 1'b0, 0);
        run_op(32'h0000_0000, 1'b1, 2);
        run_op(32'h00F0_0000, 1'b0, 3);

        start_op(32'h0000_0100, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_out_shift", 32'(out_shift), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check("no_stale_valid", 32'(out_valid), 32'd0);
        end
        run_op(32'h0000_0010, 1'b1, 0);

        for (int i = 0; i < 12; i++) begin
            r = $urandom >> $urandom_range(0, 31);
            run_op(r, 1'($urandom), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/normalize_unit.md
NORMALIZE_UNIT -- requirements
Module: normalize_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  source presents an operand.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 in_data  input  32  operand to normalize.
REQ-007 in_mode  input  1  0 = left-normalize (count leading zeros), 1 = right-normalize (count trailing zeros).
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  sink accepts the result.
REQ-010 out_data  output  32  normalized operand.
REQ-011 out_shift  output  6  shift amount recovered, 0..32.
REQ-012 out_zero  output  1  operand was all zeros.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Input handshake = in_valid & in_ready at a rising edge; on it, in_data, in_mode latched, shift count cleared, zero flag = (in_data == 0), step index = 0, state -> RUN.
REQ-016 RUN SHALL perform one step per edge, step sizes 16, 8, 4, 2, 1 in order (step index 0..4).
REQ-017 Mode 0 step k: if upper k bits of working register are zero, register <<= k (zero fill) and count += k; else no change.
REQ-018 Mode 1 step k: if lower k bits of working register are zero, register >>= k (logical, zero fill) and count += k; else no change.
REQ-019 After the step-1 edge, state SHALL be DONE; out_valid high from fifth edge after accept edge (fixed latency, independent of data).
REQ-020 Zero operand: out_data = 0, out_shift = 32 (6'd32), out_zero = 1, same latency; steps SHALL NOT saturate below 32.
REQ-021 Non-zero operand: out_zero = 0, out_shift in 0..31, out_data bit 31 (mode 0) or bit 0 (mode 1) = 1.
REQ-022 In DONE, out_data, out_shift, out_zero SHALL hold stable while out_ready = 0.
REQ-023 Output handshake = out_valid & out_ready at an edge; state -> IDLE; in_ready high next cycle; no accept on the same edge (one operand per 7+ cycles).
REQ-024 in_data, in_mode, in_valid changes during RUN/DONE SHALL be ignored.
REQ-025 out_ready during IDLE/RUN SHALL have no effect.
REQ-026 out_data/out_shift/out_zero SHALL reflect the working registers continuously; only meaningful while out_valid = 1.

Reset
REQ-027 rst_n = 0 SHALL immediately force state IDLE, working register 0, count 0, zero flag 0, step index 0.
REQ-028 During and after reset: in_ready = 1, out_valid = 0, out_data = 0, out_shift = 0, out_zero = 0.
REQ-029 Reset in RUN or DONE SHALL discard the in-flight operand; no out_valid pulse for it.
REQ-030 First accept SHALL be possible on the first rising edge with rst_n = 1.

Verification
REQ-031 0x0000_0001, mode 0 -> after 5 edges out_valid = 1, out_data = 0x8000_0000, out_shift = 31, out_zero = 0.
REQ-032 0x8000_0000, mode 1 -> out_data = 0x0000_0001, out_shift = 31; same operand mode 0 -> out_data = 0x8000_0000, out_shift = 0.
REQ-033 0x0000_0000, either mode -> out_data = 0, out_shift = 32, out_zero = 1, latency 5.
REQ-034 0x00F0_0000, mode 0, out_ready low 3 cycles -> out_data = 0xF000_0000, out_shift = 8 held stable, in_ready = 0 throughout; in_ready = 1 cycle after out_ready handshake.
REQ-035 Reset asserted 2 edges after accepting 0x0000_0100 -> all outputs 0, in_ready = 1, no out_valid; next operand 0x0000_0010 mode 1 -> out_data = 0x0000_0001, out_shift = 4.
REQ-036 in_data toggled every cycle during RUN -> result matches latched operand only.
